// File: rtl/conv_compute_stride_seq_if.sv
// Frame handshake bundle for conv_compute_stride_seq: operands in, dot products out.
// master = producer/consumer side, slave = the compute block.
interface conv_compute_stride_seq_if #(
    parameter int NUM_WINDOWS  = 4,
    parameter int KERNEL_SIZE  = 25,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 22
);
    logic [NUM_WINDOWS*KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0]     pxl_vals_i;
    logic [NUM_WINDOWS-1:0][KERNEL_SIZE-1:0][WEIGHT_WIDTH-1:0] weight_vals_i;
    logic                                                    in_valid_i;
    logic                                                    in_ready_o;
    logic [NUM_WINDOWS-1:0][OUTPUT_WIDTH-1:0]                res_vals_o;
    logic                                                    out_valid_o;
    logic                                                    out_ready_i;
    logic                                                    busy_o;

    modport master (
        output pxl_vals_i,
        output weight_vals_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  res_vals_o,
        input  out_valid_o,
        input  busy_o
    );

    modport slave (
        input  pxl_vals_i,
        input  weight_vals_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output res_vals_o,
        output out_valid_o,
        output busy_o
    );
endinterface

// File: rtl/conv_compute_stride_seq.sv
// Stride dot-product engine: NUM_WINDOWS windows evaluated on NUM_MACS shared multipliers.
// Define CONV_STRIDE_RELU_EN to clamp negative results to zero after saturation.
module conv_compute_stride_seq #(
    parameter int NUM_WINDOWS  = 4,
    parameter int KERNEL_SIZE  = 25,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_MACS     = 5,
    parameter int OUTPUT_WIDTH = 22
) (
    input logic                      conv_strd_clk,
    input logic                      conv_strd_rst_b,
    conv_compute_stride_seq_if.slave bus
);
    localparam int BEATS  = (KERNEL_SIZE + NUM_MACS - 1) / NUM_MACS;
    localparam int ACC_W  = PIXEL_WIDTH + WEIGHT_WIDTH + 1 + $clog2(KERNEL_SIZE);
    localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
    localparam int NTAPS  = NUM_WINDOWS * KERNEL_SIZE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WIN_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
    localparam int TAP_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int PIX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    localparam longint SAT_MAX = (64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1;
    localparam longint SAT_MIN = -SAT_MAX - 64'sd1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WIN_W-1:0]  LAST_WIN  = WIN_W'(NUM_WINDOWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [NTAPS-1:0][PIXEL_WIDTH-1:0]                       pxl_q;
    logic [NUM_WINDOWS-1:0][KERNEL_SIZE-1:0][WEIGHT_WIDTH-1:0] wgt_q;
    logic [NUM_WINDOWS-1:0][OUTPUT_WIDTH-1:0]                res_q;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] beat_sum;
    logic [BEAT_W-1:0]       beat_q;
    logic [WIN_W-1:0]        win_q;

    logic signed [PIXEL_WIDTH:0]    px;
    logic signed [WEIGHT_WIDTH-1:0] wt;
    logic signed [PROD_W-1:0]       prod;
    logic signed [63:0]             acc_ext;
    logic [OUTPUT_WIDTH-1:0]        res_val;
    int                             tap;

    logic accept;
    logic last_beat;
    logic last_win;

    assign bus.in_ready_o  = (state_q == IDLE) ||
                             ((state_q == DONE) && bus.out_ready_i);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q == COMPUTE);
    assign bus.res_vals_o  = res_q;

    assign accept    = bus.in_valid_i && bus.in_ready_o;
    assign last_beat = (beat_q == LAST_BEAT);
    assign last_win  = (win_q == LAST_WIN);

    // Taps past KERNEL_SIZE in the final beat are padding and add nothing.
    always_comb begin
        beat_sum = '0;
        px       = '0;
        wt       = '0;
        prod     = '0;
        tap      = 0;
        for (int m = 0; m < NUM_MACS; m++) begin
            tap = int'(beat_q) * NUM_MACS + m;
            if (tap < KERNEL_SIZE) begin
                px = $signed({1'b0,
                    pxl_q[PIX_W'(int'(win_q) * KERNEL_SIZE + tap)]});
                wt = $signed(wgt_q[win_q][TAP_W'(tap)]);
                prod = px * wt;
                beat_sum = beat_sum + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        acc_d   = ((beat_q == '0) ? '0 : acc_q) + beat_sum;
        acc_ext = 64'(acc_d);
        res_val = OUTPUT_WIDTH'(acc_d);
        if (acc_ext > SAT_MAX) begin
            res_val = OUTPUT_WIDTH'(SAT_MAX);
        end else if (acc_ext < SAT_MIN) begin
            res_val = OUTPUT_WIDTH'(SAT_MIN);
        end
`ifdef CONV_STRIDE_RELU_EN
        if (res_val[OUTPUT_WIDTH-1]) begin
            res_val = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (last_beat && last_win) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = bus.in_valid_i ? COMPUTE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge conv_strd_clk or negedge conv_strd_rst_b) begin
        if (!conv_strd_rst_b) begin
            state_q <= IDLE;
            pxl_q   <= '0;
            wgt_q   <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pxl_q  <= bus.pxl_vals_i;
                wgt_q  <= bus.weight_vals_i;
                acc_q  <= '0;
                beat_q <= '0;
                win_q  <= '0;
            end else if (state_q == COMPUTE) begin
                acc_q <= acc_d;
                if (last_beat) begin
                    beat_q       <= '0;
                    res_q[win_q] <= res_val;
                    win_q        <= last_win ? '0 : win_q + WIN_W'(1);
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_compute_stride_seq.sv
// Bench for conv_compute_stride_seq: default build plus a NUM_MACS=4 / 16-bit output
// instance, table vectors and scoreboard queues checked on each output handshake.
module tb_conv_compute_stride_seq;
    localparam int NW    = 4;
    localparam int KS    = 25;
    localparam int OWA   = 22;
    localparam int OWB   = 16;
    localparam int LAT_A = 20;
    localparam int LAT_B = 28;

    typedef logic [NW-1:0][31:0] res4_t;
    typedef struct {
        logic [7:0]         p;
        logic [NW-1:0][7:0] w;
        res4_t              ea;
        res4_t              eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NW*KS-1:0][7:0]       pxl = '0;
    logic [NW-1:0][KS-1:0][7:0]  wgt = '0;
    logic vld_a = 1'b0;
    logic vld_b = 1'b0;
    logic rdy   = 1'b1;

    conv_compute_stride_seq_if #(.OUTPUT_WIDTH(OWA)) ia ();
    conv_compute_stride_seq_if #(.OUTPUT_WIDTH(OWB)) ib ();

    assign ia.pxl_vals_i    = pxl;
    assign ia.weight_vals_i = wgt;
    assign ia.in_valid_i    = vld_a;
    assign ia.out_ready_i   = rdy;
    assign ib.pxl_vals_i    = pxl;
    assign ib.weight_vals_i = wgt;
    assign ib.in_valid_i    = vld_b;
    assign ib.out_ready_i   = rdy;

    conv_compute_stride_seq #(.OUTPUT_WIDTH(OWA)) dut_a (
        .conv_strd_clk  (clk),
        .conv_strd_rst_b(rst_n),
        .bus            (ia)
    );

    conv_compute_stride_seq #(.NUM_MACS(4), .OUTPUT_WIDTH(OWB)) dut_b (
        .conv_strd_clk  (clk),
        .conv_strd_rst_b(rst_n),
        .bus            (ib)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    res4_t qa[$];
    res4_t qb[$];
    int    acc_a[$];
    int    acc_b[$];
    res4_t ea_m;
    res4_t eb_m;
    logic  ova_prev = 1'b0;
    logic  ovb_prev = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    function automatic longint fin(input longint v, input int ow);
        longint mx;
        longint mn;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (v > mx) v = mx;
        if (v < mn) v = mn;
`ifdef CONV_STRIDE_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    function automatic res4_t fin4(input res4_t e, input int ow);
        res4_t r;
        for (int w = 0; w < NW; w++)
            r[w] = 32'(fin(longint'($signed(e[w])), ow));
        return r;
    endfunction

    function automatic res4_t model(input int ow);
        res4_t r;
        longint s;
        for (int w = 0; w < NW; w++) begin
            s = 0;
            for (int t = 0; t < KS; t++)
                s += longint'(pxl[w*KS+t]) * longint'($signed(wgt[w][t]));
            r[w] = 32'(fin(s, ow));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ia.in_valid_i && ia.in_ready_o) acc_a.push_back(cyc + 1);
            if (ia.out_valid_o && !ova_prev) begin
                if (acc_a.size() == 0) note_fail("a_spurious_valid");
                else check("a_latency", longint'(cyc - acc_a.pop_front()), LAT_A);
            end
            if (ia.out_valid_o && ia.out_ready_i) begin
                if (qa.size() == 0) note_fail("a_unexpected_output");
                else begin
                    ea_m = qa.pop_front();
                    for (int w = 0; w < NW; w++)
                        check($sformatf("a_res_w%0d", w),
                              longint'($signed(ia.res_vals_o[w])),
                              longint'($signed(ea_m[w])));
                end
            end
        end
        ova_prev <= rst_n && ia.out_valid_o;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ib.in_valid_i && ib.in_ready_o) acc_b.push_back(cyc + 1);
            if (ib.out_valid_o && !ovb_prev) begin
                if (acc_b.size() == 0) note_fail("b_spurious_valid");
                else check("b_latency", longint'(cyc - acc_b.pop_front()), LAT_B);
            end
            if (ib.out_valid_o && ib.out_ready_i) begin
                if (qb.size() == 0) note_fail("b_unexpected_output");
                else begin
                    eb_m = qb.pop_front();
                    for (int w = 0; w < NW; w++)
                        check($sformatf("b_res_w%0d", w),
                              longint'($signed(ib.res_vals_o[w])),
                              longint'($signed(eb_m[w])));
                end
            end
        end
        ovb_prev <= rst_n && ib.out_valid_o;
    end

    task automatic wait_ready(input bit both);
        for (int n = 0; n < 200; n++) begin
            if (ia.in_ready_o && (!both || ib.in_ready_o)) return;
            @(posedge clk);
            #1;
        end
        note_fail("ready_timeout");
    endtask

    task automatic send(input bit both, input res4_t ea, input res4_t eb);
        wait_ready(both);
        qa.push_back(ea);
        if (both) qb.push_back(eb);
        vld_a = 1'b1;
        vld_b = both;
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            if (qa.size() == 0 && qb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        note_fail("drain_timeout");
    endtask

    task automatic ones_frame(input logic [7:0] p);
        pxl = {NW*KS{p}};
        wgt = {NW{{KS{8'd1}}}};
    endtask

    vec_t tbl[6];
    int   t_acc[3];
    int   cnt;

    initial begin
        tbl[0] = '{8'd1, {4{8'd1}}, {4{32'd25}}, {4{32'd25}}};
        tbl[1] = '{8'd255, {4{8'h80}}, {4{-32'sd816000}}, {4{-32'sd32768}}};
        tbl[2] = '{8'd255, {4{8'h7f}}, {4{32'd809625}}, {4{32'd32767}}};
        tbl[3] = '{8'd2, {8'd4, 8'd3, 8'd2, 8'd1},
                   {32'd200, 32'd150, 32'd100, 32'd50},
                   {32'd200, 32'd150, 32'd100, 32'd50}};
        tbl[4] = '{8'd0, {4{8'hff}}, {4{32'd0}}, {4{32'd0}}};
        tbl[5] = '{8'd3, {8'h00, 8'hf9, 8'h05, 8'hff},
                   {32'd0, -32'sd525, 32'd375, -32'sd75},
                   {32'd0, -32'sd525, 32'd375, -32'sd75}};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready_a", longint'(ia.in_ready_o), 1);
        check("rst_in_ready_b", longint'(ib.in_ready_o), 1);
        check("rst_out_valid_a", longint'(ia.out_valid_o), 0);
        check("rst_busy_a", longint'(ia.busy_o), 0);
        check("rst_res_a", longint'(|ia.res_vals_o), 0);

        for (int i = 0; i < 6; i++) begin
            pxl = {NW*KS{tbl[i].p}};
            for (int w = 0; w < NW; w++) wgt[w] = {KS{tbl[i].w[w]}};
            send(1'b1, fin4(tbl[i].ea, OWA), fin4(tbl[i].eb, OWB));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NW*KS; i++) pxl[i] = 8'($urandom);
            for (int w = 0; w < NW; w++)
                for (int t = 0; t < KS; t++) wgt[w][t] = 8'($urandom);
            send(1'b1, model(OWA), model(OWB));
        end
        drain();

        // Downstream stall holds the result.
        rdy = 1'b0;
        pxl = {NW*KS{8'd2}};
        for (int w = 0; w < NW; w++) wgt[w] = {KS{8'(w + 1)}};
        send(1'b0, fin4({32'd200, 32'd150, 32'd100, 32'd50}, OWA), '0);
        for (int n = 0; n < 100 && !ia.out_valid_o; n++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", longint'(ia.out_valid_o), 1);
            check("stall_in_ready", longint'(ia.in_ready_o), 0);
            for (int w = 0; w < NW; w++)
                check("stall_res", longint'($signed(ia.res_vals_o[w])),
                      fin(longint'(50 * (w + 1)), OWA));
        end
        rdy = 1'b1;
        drain();

        // Back-to-back frames with in_valid held high.
        ones_frame(8'd1);
        vld_a = 1'b1;
        qa.push_back(fin4({NW{32'd25}}, OWA));
        for (int k = 0; k < 3; k++) begin
            wait_ready(1'b0);
            @(posedge clk);
            #1;
            t_acc[k] = cyc;
            if (k < 2) begin
                pxl = {NW*KS{8'(k + 2)}};
                qa.push_back(fin4({NW{32'(25 * (k + 2))}}, OWA));
            end else begin
                vld_a = 1'b0;
            end
        end
        check("b2b_gap1", longint'(t_acc[1] - t_acc[0]), 21);
        check("b2b_gap2", longint'(t_acc[2] - t_acc[1]), 21);
        drain();

        // Reset in the middle of a frame.
        ones_frame(8'd1);
        send(1'b0, fin4({NW{32'd25}}, OWA), '0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(ia.out_valid_o), 0);
        check("midrst_busy", longint'(ia.busy_o), 0);
        check("midrst_res", longint'(|ia.res_vals_o), 0);
        acc_a.delete();
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_in_ready", longint'(ia.in_ready_o), 1);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ia.out_valid_o) cnt++;
        end
        check("midrst_no_valid", longint'(cnt), 0);
        ones_frame(8'd1);
        send(1'b0, fin4({NW{32'd25}}, OWA), '0);
        drain();

        check("queue_a_empty", longint'(qa.size()), 0);
        check("queue_b_empty", longint'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
